// File: rtl/rsc_mem_pkg.sv
// Shared types and widths for the RSC memory-port responder.
package rsc_mem_pkg;

    localparam int RSC_WORD_W = 16;
    localparam int RSC_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } rsc_state_e;

endpackage

// File: rtl/rsc_mem_array.sv
// Single-port word RAM with a registered read port; contents are not reset.
module rsc_mem_array
    import rsc_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  index,
    input  logic [RSC_WORD_W-1:0] wdata,
    output logic [RSC_WORD_W-1:0] rdata
);

    logic [RSC_WORD_W-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
        rdata <= mem_q[index];
    end

endmodule

// File: rtl/rsc_mem_responder.sv
// Far end of the MAR/MDR memory port: IDLE accepts, BUSY counts wait states then accesses, ACK holds until req drops.
// Define RSC_MEM_BOUNDS_EN to reject addresses above the implemented RAM (memErr); otherwise they alias.
module rsc_mem_responder
    import rsc_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RSC_ADDR_W-1:0] memAddress,
    input  logic [RSC_WORD_W-1:0] memDataIn,
    input  logic                  memReq,
    input  logic                  memWe,
    output logic [RSC_WORD_W-1:0] memDataOut,
    output logic                  memAck,
    output logic                  memErr
);

    localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    rsc_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_BITS-1:0]  idx_q;
    logic [RSC_WORD_W-1:0] wdata_q;
    logic [RSC_WORD_W-1:0] dout_q;
    logic                  we_q;
    logic                  oor_q;
    logic                  ack_q;
    logic                  err_q;

    logic                  oor_d;
    logic                  addr_hi_nz;
    logic                  access;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_idx;
    logic [RSC_WORD_W-1:0] ram_rdata;

    assign addr_hi_nz = |memAddress[RSC_ADDR_W-1:ADDR_BITS];

`ifdef RSC_MEM_BOUNDS_EN
    assign oor_d = addr_hi_nz;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = addr_hi_nz;
    assign oor_d          = 1'b0;
`endif

    // Point the RAM at the incoming address while idle so the read word is ready even with zero wait states.
    assign ram_idx = (state_q == IDLE) ? memAddress[ADDR_BITS-1:0] : idx_q;
    assign access  = (state_q == BUSY) && (cnt_q == '0);
    assign ram_we  = access && we_q && !oor_q && !rst;

    rsc_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .index (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memReq) begin
                        idx_q   <= memAddress[ADDR_BITS-1:0];
                        wdata_q <= memDataIn;
                        we_q    <= memWe;
                        oor_q   <= oor_d;
                        cnt_q   <= CNT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (!we_q) begin
                            dout_q <= oor_q ? '0 : ram_rdata;
                        end
                        err_q   <= oor_q;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!memReq) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memDataOut = dout_q;
    assign memAck     = ack_q;
    assign memErr     = err_q;

endmodule

// File: tb/tb_rsc_mem_responder.sv
// Directed bench for rsc_mem_responder: default instance (WAIT_STATES=2) and a zero-wait instance.
module tb_rsc_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addrA, dinA, doutA, addrB, dinB, doutB;
   logic        reqA, weA, ackA, errA, reqB, weB, ackB, errB;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rsc_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(2)) dut_a (
      .clk(clk), .rst(rst), .memAddress(addrA), .memDataIn(dinA), .memReq(reqA),
      .memWe(weA), .memDataOut(doutA), .memAck(ackA), .memErr(errA)
   );

   rsc_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut_b (
      .clk(clk), .rst(rst), .memAddress(addrB), .memDataIn(dinB), .memReq(reqB),
      .memWe(weB), .memDataOut(doutB), .memAck(ackB), .memErr(errB)
   );

   task automatic chk(input string tag, input bit ok);
      checks++;
      if (!ok) begin
         failures++;
         $error("FAIL %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic req, input logic we,
                        input logic [15:0] a, input logic [15:0] d);
      if (!sel) begin
         reqA = req; weA = we; addrA = a; dinA = d;
      end else begin
         reqB = req; weB = we; addrB = a; dinB = d;
      end
   endtask

   function automatic logic ack_of(input bit sel);
      return sel ? ackB : ackA;
   endfunction

   task automatic acc(input bit sel, input logic we, input logic [15:0] a, input logic [15:0] d,
                      input int exp_lat, input int hold, input string tag,
                      output logic [15:0] dout, output logic err);
      int n;
      drive(sel, 1'b1, we, a, d);
      step();
      drive(sel, 1'b1, we, a ^ 16'h0001, ~d);
      n = 0;
      while (ack_of(sel) !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, n === exp_lat);
      dout = sel ? doutB : doutA;
      err  = sel ? errB : errA;
      n = 0;
      for (int i = 0; i < hold; i++) begin
         step();
         if (ack_of(sel) === 1'b1) n++;
      end
      if (hold > 0) chk({tag, "_hold"}, n === hold);
      drive(sel, 1'b0, we, a, d);
      step();
      chk({tag, "_release"}, ack_of(sel) === 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] rd;
      logic        er;
      int          n;

      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      step();
      rst = 1'b0;
      chk("rst_ackA", ackA === 1'b0);
      chk("rst_errA", errA === 1'b0);
      chk("rst_doutA", doutA === 16'h0000);
      chk("rst_ackB", ackB === 1'b0);
      chk("rst_doutB", doutB === 16'h0000);

      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ackA === 1'b0 && doutA === 16'h0000) n++;
      end
      chk("idle_quiet", n === 5);

      acc(0, 1'b1, 16'h0012, 16'hBEEF, 3, 0, "wr_beef", rd, er);
      acc(0, 1'b0, 16'h0012, 16'h0000, 3, 0, "rd_beef", rd, er);
      chk("rd_beef_data", rd === 16'hBEEF);
      chk("rd_beef_err", er === 1'b0);

      acc(0, 1'b1, 16'h0021, 16'h7777, 3, 0, "wr_7777", rd, er);
      acc(0, 1'b1, 16'h0020, 16'h1111, 3, 4, "wr_hold", rd, er);
      chk("dout_kept_on_write", doutA === 16'hBEEF);
      acc(0, 1'b0, 16'h0021, 16'h0000, 3, 0, "rd_21", rd, er);
      chk("no_repeat_access", rd === 16'h7777);
      acc(0, 1'b0, 16'h0020, 16'h0000, 3, 0, "rd_20", rd, er);
      chk("rd_20_data", rd === 16'h1111);

      acc(0, 1'b1, 16'h0040, 16'h5555, 3, 0, "wr_5555", rd, er);
      drive(0, 1'b1, 1'b1, 16'h0040, 16'h1234);
      step();
      step();
      step();
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      rst = 1'b0;
      chk("rst_busy_ack", ackA === 1'b0);
      step();
      acc(0, 1'b0, 16'h0040, 16'h0000, 3, 0, "rd_40", rd, er);
      chk("aborted_write_dropped", rd === 16'h5555);

      acc(0, 1'b1, 16'h0001, 16'h1357, 3, 0, "wr_1", rd, er);
      acc(0, 1'b1, 16'h0401, 16'hAAAA, 3, 0, "wr_401", rd, er);
`ifdef RSC_MEM_BOUNDS_EN
      chk("wr_401_err", er === 1'b1);
      acc(0, 1'b0, 16'h0001, 16'h0000, 3, 0, "rd_1", rd, er);
      chk("rd_1_data", rd === 16'h1357);
      acc(0, 1'b0, 16'h0401, 16'h0000, 3, 0, "rd_401", rd, er);
      chk("rd_401_data", rd === 16'h0000);
      chk("rd_401_err", er === 1'b1);
`else
      chk("wr_401_err", er === 1'b0);
      acc(0, 1'b0, 16'h0001, 16'h0000, 3, 0, "rd_1", rd, er);
      chk("rd_1_data", rd === 16'hAAAA);
      chk("rd_1_err", er === 1'b0);
`endif
      chk("err_clears", errA === 1'b0);

      acc(1, 1'b1, 16'h00C3, 16'h0F0F, 1, 0, "b_wr_0f0f", rd, er);
      acc(1, 1'b0, 16'h00C3, 16'h0000, 1, 0, "b_rd_0f0f", rd, er);
      chk("b_rd_0f0f_data", rd === 16'h0F0F);
      acc(1, 1'b1, 16'h00C3, 16'hF0F0, 1, 0, "b_wr_f0f0", rd, er);
      chk("b_dout_kept", doutB === 16'h0F0F);
      acc(1, 1'b0, 16'h00C3, 16'h0000, 1, 0, "b_rd_f0f0", rd, er);
      chk("b_rd_f0f0_data", rd === 16'hF0F0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
